// File: rtl/dmem_portb_arbiter.sv
// DMEM port-B arbiter: grants accelerator row reads or CCD row writes, registers the
// winning command onto the ram port and tracks read returns with a valid pipeline.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  PRI_ACC | accelerator wins ties; CCD wins only when acc is not asking
//  PRI_CCD | CCD wins ties after starving; left after the next CCD grant
module dmem_portb_arbiter #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 256,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              acc_rd_req,
   input  logic [ADDR_W-1:0] acc_rd_addr,
   output logic              acc_rd_gnt,
   output logic              acc_rd_valid,
   output logic [DATA_W-1:0] acc_rd_data,
   input  logic              ccd_wr_req,
   input  logic [ADDR_W-1:0] ccd_wr_addr,
   input  logic [DATA_W-1:0] ccd_wr_data,
   output logic              ccd_wr_gnt,
   output logic [ADDR_W-1:0] ram_address_b,
   output logic [DATA_W-1:0] ram_data_b,
   output logic              ram_rden_b,
   output logic              ram_wren_b,
   input  logic [DATA_W-1:0] ram_q_b,
   output logic [2:0]        rd_inflight
);

   localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

   typedef enum logic {PRI_ACC, PRI_CCD} pri_t;

   pri_t                state_q, state_d;
   logic [7:0]          starve_q, starve_d;
   logic [READ_LAT-1:0] vld_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PRI_ACC;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      acc_rd_gnt = 1'b0;
      ccd_wr_gnt = 1'b0;
      state_d    = state_q;
      starve_d   = starve_q;
      case (state_q)
         PRI_ACC: begin
            acc_rd_gnt = acc_rd_req;
            ccd_wr_gnt = ccd_wr_req & ~acc_rd_req;
         end
         PRI_CCD: begin
            ccd_wr_gnt = ccd_wr_req;
            acc_rd_gnt = acc_rd_req & ~ccd_wr_req;
         end
         default: ;
      endcase
      if (!ccd_wr_req || ccd_wr_gnt)
         starve_d = '0;
      else if (starve_q < STARVE_LIM)
         starve_d = starve_q + 8'd1;
      // Switch on the cycle the count reaches the limit so CCD wins the very next cycle.
      if (state_q == PRI_CCD && ccd_wr_gnt)
         state_d = PRI_ACC;
      else if (state_q == PRI_ACC && starve_d == STARVE_LIM)
         state_d = PRI_CCD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_address_b <= '0;
         ram_data_b    <= '0;
         ram_rden_b    <= 1'b0;
         ram_wren_b    <= 1'b0;
      end else begin
         ram_rden_b <= acc_rd_gnt;
         ram_wren_b <= ccd_wr_gnt;
         if (acc_rd_gnt) begin
            ram_address_b <= acc_rd_addr;
         end else if (ccd_wr_gnt) begin
            ram_address_b <= ccd_wr_addr;
            ram_data_b    <= ccd_wr_data;
         end
      end
   end

   // Issued read enters the pipe one cycle after the grant; tail is READ_LAT cycles later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= ram_rden_b;
         for (int i = 1; i < READ_LAT; i++)
            vld_sr[i] <= vld_sr[i-1];
      end
   end

   assign acc_rd_valid = vld_sr[READ_LAT-1];
   assign acc_rd_data  = ram_q_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_inflight <= '0;
      end else begin
         case ({acc_rd_gnt, acc_rd_valid})
            2'b10:   rd_inflight <= rd_inflight + 3'd1;
            2'b01:   rd_inflight <= rd_inflight - 3'd1;
            default: rd_inflight <= rd_inflight;
         endcase
      end
   end

endmodule
